// File: rtl/dcache_port_arbiter.sv
// Arbitrates load, store-drain and maintenance requesters onto a single dcache port.
// One operation is outstanding at a time; stores gain priority after STARVE_MAX load grants.
module dcache_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_req_i,
  input  logic [ADDR_W-1:0]     ld_addr_i,
  output logic                  ld_ack_o,
  output logic [DATA_W-1:0]     ld_rdata_o,
  input  logic                  st_req_i,
  input  logic [ADDR_W-1:0]     st_addr_i,
  input  logic [DATA_W-1:0]     st_wdata_i,
  input  logic [DATA_W/8-1:0]   st_sel_i,
  output logic                  st_ack_o,
  input  logic                  flush_req_i,
  input  logic                  kill_req_i,
  output logic                  mnt_ack_o,
  output logic                  dc_req_o,
  output logic                  dc_w_en_o,
  output logic                  dc_flush_o,
  output logic                  dc_kill_o,
  output logic [ADDR_W-1:0]     dc_addr_o,
  output logic [DATA_W-1:0]     dc_wdata_o,
  output logic [DATA_W/8-1:0]   dc_sel_o,
  input  logic                  dc_ack_i,
  input  logic [DATA_W-1:0]     dc_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, MAINT} state_t;

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_cnt_next;
  logic       starved;
  logic       grant_ld, grant_st, grant_mnt;
  logic       op_done;

  assign starved = st_req_i && (starve_cnt >= STARVE_LIM);

  always_comb begin
    state_next = state;
    grant_ld   = 1'b0;
    grant_st   = 1'b0;
    grant_mnt  = 1'b0;
    ld_ack_o   = 1'b0;
    st_ack_o   = 1'b0;
    mnt_ack_o  = 1'b0;
    case (state)
      IDLE: begin
        // dc_ack_i is deliberately not looked at here
        if (kill_req_i || flush_req_i) begin
          grant_mnt  = 1'b1;
          state_next = MAINT;
        end else if (starved) begin
          grant_st   = 1'b1;
          state_next = STORE;
        end else if (ld_req_i) begin
          grant_ld   = 1'b1;
          state_next = LOAD;
        end else if (st_req_i) begin
          grant_st   = 1'b1;
          state_next = STORE;
        end
      end
      LOAD: begin
        if (dc_ack_i) begin
          ld_ack_o   = 1'b1;
          state_next = IDLE;
        end
      end
      STORE: begin
        if (dc_ack_i) begin
          st_ack_o   = 1'b1;
          state_next = IDLE;
        end
      end
      MAINT: begin
        if (dc_ack_i) begin
          mnt_ack_o  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign op_done    = ld_ack_o || st_ack_o || mnt_ack_o;
  assign ld_rdata_o = ld_ack_o ? dc_rdata_i : '0;

  // Counts loads that overtook a waiting store; any gap in the store request forgives it.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!st_req_i || grant_st) begin
      starve_cnt_next = '0;
    end else if (grant_ld && (starve_cnt != 4'hF)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dc_req_o   <= 1'b0;
      dc_w_en_o  <= 1'b0;
      dc_flush_o <= 1'b0;
      dc_kill_o  <= 1'b0;
      dc_addr_o  <= '0;
      dc_wdata_o <= '0;
      dc_sel_o   <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      if (grant_ld) begin
        dc_req_o   <= 1'b1;
        dc_w_en_o  <= 1'b0;
        dc_addr_o  <= ld_addr_i;
        dc_wdata_o <= '0;
        dc_sel_o   <= '0;
      end else if (grant_st) begin
        dc_req_o   <= 1'b1;
        dc_w_en_o  <= 1'b1;
        dc_addr_o  <= st_addr_i;
        dc_wdata_o <= st_wdata_i;
        dc_sel_o   <= st_sel_i;
      end else if (grant_mnt) begin
        dc_flush_o <= flush_req_i && !kill_req_i;
        dc_kill_o  <= kill_req_i;
        dc_addr_o  <= '0;
        dc_wdata_o <= '0;
        dc_sel_o   <= '0;
      end else if (op_done) begin
        dc_req_o   <= 1'b0;
        dc_w_en_o  <= 1'b0;
        dc_flush_o <= 1'b0;
        dc_kill_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed and random bench for dcache_port_arbiter: a dcache/requester environment with
// per-requester scoreboard queues, plus directed steps for the named scenarios.
module tb_dcache_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int SEL_W      = DATA_W / 8;
  localparam int STARVE_MAX = 4;
  localparam int CMD_W      = 4 + ADDR_W + DATA_W + SEL_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_req_i = 1'b0;
  logic [ADDR_W-1:0] ld_addr_i = '0;
  logic              ld_ack_o;
  logic [DATA_W-1:0] ld_rdata_o;
  logic              st_req_i = 1'b0;
  logic [ADDR_W-1:0] st_addr_i = '0;
  logic [DATA_W-1:0] st_wdata_i = '0;
  logic [SEL_W-1:0]  st_sel_i = '0;
  logic              st_ack_o;
  logic              flush_req_i = 1'b0;
  logic              kill_req_i = 1'b0;
  logic              mnt_ack_o;
  logic              dc_req_o, dc_w_en_o, dc_flush_o, dc_kill_o;
  logic [ADDR_W-1:0] dc_addr_o;
  logic [DATA_W-1:0] dc_wdata_o;
  logic [SEL_W-1:0]  dc_sel_o;
  logic              dc_ack_i = 1'b0;
  logic [DATA_W-1:0] dc_rdata_i = '0;

  dcache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i), .st_sel_i(st_sel_i),
    .st_ack_o(st_ack_o), .flush_req_i(flush_req_i), .kill_req_i(kill_req_i), .mnt_ack_o(mnt_ack_o),
    .dc_req_o(dc_req_o), .dc_w_en_o(dc_w_en_o), .dc_flush_o(dc_flush_o), .dc_kill_o(dc_kill_o),
    .dc_addr_o(dc_addr_o), .dc_wdata_o(dc_wdata_o), .dc_sel_o(dc_sel_o),
    .dc_ack_i(dc_ack_i), .dc_rdata_i(dc_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } op_t;

  int total = 0;
  int bad   = 0;

  op_t  ld_q[$];
  op_t  st_q[$];
  logic mnt_q[$];
  byte  grant_log[$];

  // Orders posted by the directed steps, consumed by the environment at the next negedge.
  int                ord_ld_cnt = 0, ord_st_cnt = 0, ord_mnt_cnt = 0;
  int                ord_ld_n = 1, ord_st_n = 1;
  logic [ADDR_W-1:0] ord_ld_addr = '0, ord_st_addr = '0;
  logic [DATA_W-1:0] ord_st_wdata = '0;
  logic [SEL_W-1:0]  ord_st_sel = '0;
  logic              ord_f = 1'b0, ord_k = 1'b0;
  int                lat_cfg = 0;
  logic              use_fixed_rd = 1'b0;
  logic [DATA_W-1:0] fixed_rdata = '0;
  logic              rand_on = 1'b0;
  logic              spur_on = 1'b0;

  // Environment-owned state.
  int                ld_taken = 0, st_taken = 0, mnt_taken = 0;
  int                ld_rem = 0, st_rem = 0;
  int                ld_done = 0, st_done = 0, mnt_done = 0;
  logic              busy = 1'b0;
  int                kind = 0;
  int                wait_cnt = 0;
  logic [CMD_W-1:0]  snap = '0;
  op_t               cur_op = '0;
  logic              cur_kill = 1'b0;
  logic              just_acked = 1'b0;
  logic              st_req_prev = 1'b0;
  int                st_wait_loads = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise_ld(input logic [ADDR_W-1:0] a);
    op_t o;
    o.addr = a; o.wdata = '0; o.sel = '0;
    ld_addr_i = a;
    ld_req_i  = 1'b1;
    ld_q.push_back(o);
  endtask

  task automatic raise_st(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s);
    op_t o;
    o.addr = a; o.wdata = d; o.sel = s;
    st_addr_i = a; st_wdata_i = d; st_sel_i = s;
    st_req_i  = 1'b1;
    st_q.push_back(o);
  endtask

  task automatic raise_mnt(input logic f, input logic k);
    flush_req_i = f;
    kill_req_i  = k;
    mnt_q.push_back(k);
  endtask

  initial begin : dcache_env
    logic [3:0]       cmd;
    logic [CMD_W-1:0] cur;
    logic [DATA_W-1:0] rd;
    logic [2:0]       exp_ack;
    logic [31:0]      r;
    logic             k;
    forever begin
      @(negedge clk);
      dc_ack_i   = 1'b0;
      dc_rdata_i = '0;
      if (rst) begin
        // An abandoned operation must be re-granted later, so its expectation goes back.
        if (busy) begin
          if (kind == 0) ld_q.push_front(cur_op);
          else if (kind == 1) st_q.push_front(cur_op);
          else if (kind == 2) mnt_q.push_front(cur_kill);
        end
        busy = 1'b0;
        just_acked = 1'b0;
        st_wait_loads = 0;
        st_req_prev = st_req_i;
      end else begin
        cmd = {dc_kill_o, dc_flush_o, dc_w_en_o, dc_req_o};
        cur = {cmd, dc_addr_o, dc_wdata_o, dc_sel_o};
        if (just_acked) chk("gap_after_ack", cmd, 4'b0000);
        just_acked = 1'b0;
        if (!busy && cmd != 4'b0000) begin
          busy = 1'b1;
          snap = cur;
          wait_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
          if (cmd == 4'b0001) begin
            kind = 0;
            grant_log.push_back("L");
            if (st_req_prev) st_wait_loads++;
            else st_wait_loads = 0;
            chk("starve_bound", st_wait_loads <= STARVE_MAX, 1'b1);
            if (ld_q.size() == 0) chk("ld_unexpected_grant", 1'b1, 1'b0);
            else begin
              cur_op = ld_q.pop_front();
              chk("ld_addr", dc_addr_o, cur_op.addr);
            end
          end else if (cmd == 4'b0011) begin
            kind = 1;
            grant_log.push_back("S");
            st_wait_loads = 0;
            if (st_q.size() == 0) chk("st_unexpected_grant", 1'b1, 1'b0);
            else begin
              cur_op = st_q.pop_front();
              chk("st_payload", {dc_addr_o, dc_wdata_o, dc_sel_o}, cur_op);
            end
          end else if (cmd == 4'b0100 || cmd == 4'b1000) begin
            kind = 2;
            grant_log.push_back(dc_kill_o ? "K" : "F");
            if (mnt_q.size() == 0) chk("mnt_unexpected_grant", 1'b1, 1'b0);
            else begin
              cur_kill = mnt_q.pop_front();
              chk("mnt_kill_sel", dc_kill_o, cur_kill);
            end
          end else begin
            kind = 3;
            chk("cmd_encoding", cmd, 4'b0000);
          end
        end else if (busy) begin
          chk("payload_stable", cur, snap);
        end

        if (busy) begin
          if (wait_cnt == 0) begin
            rd = use_fixed_rd ? fixed_rdata : DATA_W'($urandom);
            dc_ack_i   = 1'b1;
            dc_rdata_i = rd;
            #1;
            case (kind)
              0:       exp_ack = 3'b100;
              1:       exp_ack = 3'b010;
              2:       exp_ack = 3'b001;
              default: exp_ack = 3'b000;
            endcase
            chk("ack_onehot", {ld_ack_o, st_ack_o, mnt_ack_o}, exp_ack);
            if (kind == 0) begin
              chk("ld_rdata", ld_rdata_o, rd);
              ld_done++;
              if (ld_rem > 0) begin
                ld_rem--;
                raise_ld(ADDR_W'($urandom));
              end else ld_req_i = 1'b0;
            end else if (kind == 1) begin
              st_done++;
              if (st_rem > 0) begin
                st_rem--;
                r = $urandom;
                raise_st(ADDR_W'($urandom), DATA_W'($urandom), r[SEL_W-1:0]);
              end else st_req_i = 1'b0;
            end else if (kind == 2) begin
              mnt_done++;
              flush_req_i = 1'b0;
              kill_req_i  = 1'b0;
            end
            busy = 1'b0;
            just_acked = 1'b1;
          end else begin
            wait_cnt--;
            #1;
            chk("no_ack_while_waiting", {ld_ack_o, st_ack_o, mnt_ack_o, ld_rdata_o}, '0);
          end
        end else if (spur_on && $urandom_range(0, 3) == 0) begin
          dc_ack_i = 1'b1;
          #1;
          chk("idle_ack_ignored", {ld_ack_o, st_ack_o, mnt_ack_o, ld_rdata_o}, '0);
        end

        if (ord_ld_cnt != ld_taken) begin
          ld_taken = ord_ld_cnt;
          ld_rem = ord_ld_n - 1;
          raise_ld(ord_ld_addr);
        end
        if (ord_st_cnt != st_taken) begin
          st_taken = ord_st_cnt;
          st_rem = ord_st_n - 1;
          raise_st(ord_st_addr, ord_st_wdata, ord_st_sel);
        end
        if (ord_mnt_cnt != mnt_taken) begin
          mnt_taken = ord_mnt_cnt;
          raise_mnt(ord_f, ord_k);
        end

        if (rand_on) begin
          if (!ld_req_i && $urandom_range(0, 2) == 0) raise_ld(ADDR_W'($urandom));
          if (!st_req_i && $urandom_range(0, 2) == 0) begin
            r = $urandom;
            raise_st(ADDR_W'($urandom), DATA_W'($urandom), r[SEL_W-1:0]);
          end
          if (!flush_req_i && !kill_req_i && $urandom_range(0, 9) == 0) begin
            k = 1'($urandom_range(0, 1));
            raise_mnt(k ? 1'($urandom_range(0, 1)) : 1'b1, k);
          end
        end
        st_req_prev = st_req_i;
      end
    end
  end

  function automatic logic quiet();
    return !busy && !ld_req_i && !st_req_i && !flush_req_i && !kill_req_i &&
           ld_taken == ord_ld_cnt && st_taken == ord_st_cnt && mnt_taken == ord_mnt_cnt &&
           !dc_req_o && !dc_flush_o && !dc_kill_o;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!quiet() && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, quiet(), 1'b1);
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dc_cmd"}, {dc_req_o, dc_w_en_o, dc_flush_o, dc_kill_o}, 4'b0000);
    chk({tag, "_dc_payload"}, {dc_addr_o, dc_wdata_o, dc_sel_o}, '0);
    chk({tag, "_acks"}, {ld_ack_o, st_ack_o, mnt_ack_o, ld_rdata_o}, '0);
  endtask

  initial begin : stimulus
    string exp_s;
    int    base;
    int    d_ld, d_st, d_mnt;
    int    n;

    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2;

    // Single load, ack two cycles after dc_req_o.
    lat_cfg = 2;
    use_fixed_rd = 1'b1;
    fixed_rdata = 32'hDEADBEEF;
    rst = 1'b0;
    ord_ld_addr = 32'h100; ord_ld_n = 1; ord_ld_cnt++;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t1_req_after_grant", {dc_req_o, dc_w_en_o}, 2'b10);
    chk("t1_addr", dc_addr_o, 32'h100);
    drain("t1", 50);
    chk("t1_ld_done", ld_done, 1);

    // Starvation pattern with immediate acks.
    lat_cfg = 0;
    use_fixed_rd = 1'b0;
    base = grant_log.size();
    ord_ld_addr = 32'h1000; ord_ld_n = 12; ord_ld_cnt++;
    ord_st_addr = 32'h2000; ord_st_wdata = 32'hA5A5A5A5; ord_st_sel = 4'hF; ord_st_n = 3; ord_st_cnt++;
    drain("t2", 300);
    exp_s = "LLLLSLLLLSLLLLS";
    chk("t2_grant_count", grant_log.size() - base, exp_s.len());
    for (int i = 0; i < exp_s.len(); i++)
      if (base + i < grant_log.size()) chk($sformatf("t2_grant_%0d", i), grant_log[base + i], exp_s[i]);

    // Kill arriving during a store.
    lat_cfg = 3;
    base = grant_log.size();
    d_st = st_done; d_mnt = mnt_done;
    ord_st_addr = 32'h200; ord_st_wdata = 32'h12345678; ord_st_sel = 4'h5; ord_st_n = 1; ord_st_cnt++;
    n = 0;
    while (!dc_w_en_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t3_in_store", dc_w_en_o, 1'b1);
    #1;
    ord_f = 1'b0; ord_k = 1'b1; ord_mnt_cnt++;
    drain("t3", 100);
    chk("t3_st_done", st_done - d_st, 1);
    chk("t3_mnt_done", mnt_done - d_mnt, 1);
    chk("t3_grants", grant_log.size() - base, 2);
    if (base + 1 < grant_log.size()) begin
      chk("t3_first_store", grant_log[base], "S");
      chk("t3_then_kill", grant_log[base + 1], "K");
    end

    // Flush and kill together.
    lat_cfg = 1;
    base = grant_log.size();
    d_mnt = mnt_done;
    ord_f = 1'b1; ord_k = 1'b1; ord_mnt_cnt++;
    drain("t4", 50);
    repeat (4) @(posedge clk);
    chk("t4_mnt_single", mnt_done - d_mnt, 1);
    chk("t4_grants", grant_log.size() - base, 1);
    if (base < grant_log.size()) chk("t4_kill_only", grant_log[base], "K");
    #2;

    // Reset in the middle of a load.
    lat_cfg = 20;
    d_ld = ld_done;
    ord_ld_addr = 32'h300; ord_ld_n = 1; ord_ld_cnt++;
    n = 0;
    while (!dc_req_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_in_load", dc_req_o, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    lat_cfg = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("t5_no_ack_in_reset", ld_done - d_ld, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_regrant", {dc_req_o, dc_w_en_o}, 2'b10);
    chk("t5_regrant_addr", dc_addr_o, 32'h300);
    drain("t5", 50);
    chk("t5_ld_done", ld_done - d_ld, 1);

    // Random traffic.
    d_ld = ld_done; d_st = st_done; d_mnt = mnt_done;
    lat_cfg = -1;
    spur_on = 1'b1;
    rand_on = 1'b1;
    repeat (3000) @(posedge clk);
    #2;
    rand_on = 1'b0;
    spur_on = 1'b0;
    drain("t6", 500);
    chk("t6_ld_q_empty", ld_q.size(), 0);
    chk("t6_st_q_empty", st_q.size(), 0);
    chk("t6_mnt_q_empty", mnt_q.size(), 0);
    chk("t6_all_kinds_seen", (ld_done > d_ld) && (st_done > d_st) && (mnt_done > d_mnt), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
